// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator: pixel divider, column/row counters, syncs and strobes
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] pixel_column,
    output logic [9:0] pixel_row,
    output logic       video_on,
    output logic       horiz_sync,
    output logic       vert_sync,
    output logic       pix_tick,
    output logic       frame_tick
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] COL_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] ROW_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] COL_VIS  = 10'(H_VIS);
    localparam logic [9:0] ROW_VIS  = 10'(V_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic       SYNC_ON  = (SYNC_POL != 0);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       col_q, col_d;
    logic [9:0]       row_q, row_d;
    logic             video_on_q, video_on_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             pix_tick_q, pix_tick_d;
    logic             frame_tick_q, frame_tick_d;
    logic             tick;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DIV_W'(1);
        col_d = col_q;
        row_d = row_q;
        if (tick) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 10'd1;
            end else begin
                col_d = col_q + 10'd1;
            end
        end

        // Decode from next-state counters so outputs line up with the coordinates they describe
        video_on_d   = (col_d < COL_VIS) && (row_d < ROW_VIS);
        hsync_d      = ((col_d >= HS_START) && (col_d < HS_END)) ? SYNC_ON : ~SYNC_ON;
        vsync_d      = ((row_d >= VS_START) && (row_d < VS_END)) ? SYNC_ON : ~SYNC_ON;
        pix_tick_d   = tick;
        frame_tick_d = tick && (col_d == '0) && (row_d == '0);
    end

    // Reset parks the counters on the last pixel so the first tick lands on (0,0)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q        <= '0;
            col_q        <= COL_LAST;
            row_q        <= ROW_LAST;
            video_on_q   <= 1'b0;
            hsync_q      <= ~SYNC_ON;
            vsync_q      <= ~SYNC_ON;
            pix_tick_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            col_q        <= col_d;
            row_q        <= row_d;
            video_on_q   <= video_on_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            pix_tick_q   <= pix_tick_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pixel_column = col_q;
    assign pixel_row    = row_q;
    assign video_on     = video_on_q;
    assign horiz_sync   = hsync_q;
    assign vert_sync    = vsync_q;
    assign pix_tick     = pix_tick_q;
    assign frame_tick   = frame_tick_q;

endmodule
